// File: rtl/cla_nibble_driver.sv
// ---------------------------------------------------------------------------
// cla_nibble_driver
//   Drives a single registered 4-bit carry-lookahead adder slice to perform a
//   wide (4*NIBBLES-bit) unsigned add. One nibble is issued per cycle, the
//   slice carry is chained between nibbles, and the registered nibble sums are
//   collected into the full-width result.
//
// Ports
//   clk       in   rising-edge clock, shared with the adder slice
//   res       in   asynchronous active-low reset
//   start     in   request, accepted when not busy (IDLE or DONE)
//   a, b      in   W-bit operands, latched on accept
//   carry_in  in   carry into nibble 0, latched on accept
//   busy      out  high while the operation is running (excludes done cycle)
//   done      out  one-cycle pulse, sum/carry_out valid
//   sum       out  W-bit result, stable from done until the next accept
//   carry_out out  carry out of the top nibble, held with sum
//   sx, sy    out  slice operand nibbles
//   scin      out  slice carry in
//   sz        in   slice registered sum (two edges after sx/sy)
//   scout     in   slice carry out (from registered operands and current scin)
// ---------------------------------------------------------------------------
module cla_nibble_driver #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   carry_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry_out,
  output logic [3:0]             sx,
  output logic [3:0]             sy,
  output logic                   scin,
  input  logic [3:0]             sz,
  input  logic                   scout
);

  localparam int W  = 4 * NIBBLES;
  localparam int JW = $clog2(NIBBLES + 2);

  localparam logic [JW-1:0] J_ZERO = {JW{1'b0}};
  localparam logic [JW-1:0] J_ONE  = JW'(1);
  localparam logic [JW-1:0] J_N    = JW'(NIBBLES);
  localparam logic [JW-1:0] J_LAST = JW'(NIBBLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            accept_s;

  // A new request is taken in IDLE and also in the DONE cycle (back-to-back).
  assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (j_q == J_LAST) state_d = S_DONE;
        else               state_d = S_RUN;
      end
      S_DONE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: operand latches, cycle index, carry chain, result.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      j_q     <= J_ZERO;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
    end else begin
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Datapath next-state: latch on accept, otherwise step through the nibbles.
  always_comb begin
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept_s) begin
      a_d   = a;
      b_d   = b;
      cin_d = carry_in;
      j_d   = J_ZERO;
    end else if (state_q == S_RUN) begin
      if (j_q == J_LAST) j_d = J_ZERO;
      else               j_d = j_q + J_ONE;
      // scout in cycle j is the carry out of nibble j-1.
      if ((j_q >= J_ONE) && (j_q <= J_N)) carry_d = scout;
      else                                carry_d = carry_q;
      if (j_q == J_N) cout_d = scout;
      else            cout_d = cout_q;
      // sz in cycle j holds the sum of nibble j-2.
      for (int k = 0; k < NIBBLES; k++) begin
        if (j_q == JW'(k + 2)) sum_d[4*k +: 4] = sz;
        else                   sum_d[4*k +: 4] = sum_q[4*k +: 4];
      end
    end else begin
      j_d = j_q;
    end
  end

  // Output decode from state and registered datapath.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    sx   = 4'd0;
    sy   = 4'd0;
    scin = 1'b0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (j_q == JW'(k)) begin
          sx = a_q[4*k +: 4];
          sy = b_q[4*k +: 4];
        end else begin
          sx = sx;
          sy = sy;
        end
      end
      // Nibble 0 takes the latched carry_in; later nibbles take the chained carry.
      if (j_q == J_ONE)                              scin = cin_q;
      else if ((j_q > J_ONE) && (j_q <= J_N))        scin = carry_q;
      else                                           scin = 1'b0;
    end else begin
      scin = 1'b0;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
